// File: rtl/barret_211_sched.sv
// Round-robin scheduler sharing one Barrett reduction datapath (mod Q) between NUM_REQ requesters.
// One multiplier is time-shared across the two Barrett products; results leave on a tagged valid/ready port.
module barret_211_sched #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 2,
  parameter int Q       = 211,
  parameter int MU      = 310,
  parameter int SHIFT   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*15-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  dout_valid,
  output logic [7:0]            dout_r,
  output logic [TAG_W-1:0]      dout_tag,
  input  logic                  dout_ready,
  output logic                  busy
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_MUL_MU = 3'd1,
    S_MUL_Q  = 3'd2,
    S_SUB    = 3'd3,
    S_CORR1  = 3'd4,
    S_CORR2  = 3'd5,
    S_DONE   = 3'd6
  } state_e;

  state_e             state_q, state_d;
  logic [TAG_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [14:0]        a_q, a_d;
  logic [16:0]        p_q, p_d;
  logic [16:0]        m_q, m_d;
  logic [15:0]        r_q, r_d;
  logic [7:0]         dout_r_q, dout_r_d;

  logic               grant_found_s;
  logic [TAG_W-1:0]   grant_idx_s;
  logic [TAG_W-1:0]   cand_s;
  logic [14:0]        a_sel_s;
  logic [NUM_REQ-1:0] req_ready_s;
  logic [16:0]        op_a_s, op_b_s, prod_s;
  logic [15:0]        r_corr_s;

  function automatic logic [15:0] corr_f(input logic [15:0] r);
    return (r >= 16'(Q)) ? (r - 16'(Q)) : r;
  endfunction

  // Round-robin search: first valid requester at or above rr_ptr, wrapping.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    cand_s        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_s        = TAG_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      grant_idx_s   = (!grant_found_s && req_valid[cand_s]) ? cand_s : grant_idx_s;
      grant_found_s = grant_found_s | req_valid[cand_s];
    end
  end

  // Operand select for the granted requester.
  always_comb begin
    a_sel_s = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      a_sel_s = (grant_idx_s == TAG_W'(k)) ? req_data[15*k +: 15] : a_sel_s;
    end
  end

  // The single shared multiplier: (a>>SHIFT)*MU, then (p>>SHIFT)*Q.
  always_comb begin
    op_a_s = (state_q == S_MUL_Q) ? 17'(p_q >> SHIFT) : 17'(a_q >> SHIFT);
    op_b_s = (state_q == S_MUL_Q) ? 17'(Q) : 17'(MU);
    prod_s = op_a_s * op_b_s;
  end

  assign r_corr_s = corr_f(r_q);

  // Next-state and datapath update for the fixed seven-state schedule.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    tag_d       = tag_q;
    a_d         = a_q;
    p_d         = p_q;
    m_d         = m_q;
    r_d         = r_q;
    dout_r_d    = dout_r_q;
    req_ready_s = '0;
    case (state_q)
      S_IDLE: begin
        if (grant_found_s) begin
          req_ready_s = NUM_REQ'(1) << grant_idx_s;
          a_d         = a_sel_s;
          tag_d       = grant_idx_s;
          rr_ptr_d    = (grant_idx_s == TAG_W'(NUM_REQ - 1)) ? '0 : grant_idx_s + TAG_W'(1);
          state_d     = S_MUL_MU;
        end else begin
          state_d     = S_IDLE;
        end
      end
      S_MUL_MU: begin
        p_d     = prod_s;
        state_d = S_MUL_Q;
      end
      S_MUL_Q: begin
        m_d     = prod_s;
        state_d = S_SUB;
      end
      S_SUB: begin
        // Barrett's estimate never exceeds the true quotient, so this cannot go negative.
        r_d     = 16'({2'b00, a_q} - m_q);
        state_d = S_CORR1;
      end
      S_CORR1: begin
        r_d     = r_corr_s;
        state_d = S_CORR2;
      end
      S_CORR2: begin
        r_d      = r_corr_s;
        dout_r_d = r_corr_s[7:0];
        state_d  = S_DONE;
      end
      S_DONE: begin
        state_d = dout_ready ? S_IDLE : S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight operand.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      tag_q    <= '0;
      a_q      <= 15'd0;
      p_q      <= 17'd0;
      m_q      <= 17'd0;
      r_q      <= 16'd0;
      dout_r_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      tag_q    <= tag_d;
      a_q      <= a_d;
      p_q      <= p_d;
      m_q      <= m_d;
      r_q      <= r_d;
      dout_r_q <= dout_r_d;
    end
  end

  assign req_ready  = req_ready_s & {NUM_REQ{~rst}};
  assign dout_valid = (state_q == S_DONE);
  assign busy       = (state_q != S_IDLE);
  assign dout_r     = dout_r_q;
  assign dout_tag   = tag_q;

endmodule

// File: tb/tb_barret_211_sched.sv
// Directed bench for barret_211_sched: a per-cycle behavioural model plus hand-computed residues.
module tb_barret_211_sched;
  localparam int N  = 4;
  localparam int TW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N*15-1:0] req_data = '0;
  logic [N-1:0]    req_ready;
  logic            dout_valid;
  logic [7:0]      dout_r;
  logic [TW-1:0]   dout_tag;
  logic            dout_ready = 1'b1;
  logic            busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  barret_211_sched #(.NUM_REQ(N), .TAG_W(TW), .Q(211), .MU(310), .SHIFT(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .dout_valid(dout_valid), .dout_r(dout_r),
    .dout_tag(dout_tag), .dout_ready(dout_ready), .busy(busy)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int first_valid(input logic [N-1:0] v, input int rr);
    for (int k = 0; k < N; k++) begin
      if (v[(rr + k) % N]) return (rr + k) % N;
    end
    return -1;
  endfunction

  function automatic int operand_of(input int idx);
    return int'(req_data[15*idx +: 15]);
  endfunction

  // Model: phase 0 = waiting for a grant, 1..5 = computing, 6 = result offered.
  int m_phase = 0;
  int m_rr    = 0;
  int m_a     = 0;
  int m_tag   = 0;

  always @(posedge clk or posedge rst) begin
    int g;
    if (rst) begin
      m_phase <= 0;
      m_rr    <= 0;
    end else if (m_phase == 0) begin
      g = first_valid(req_valid, m_rr);
      if (g >= 0) begin
        m_a     <= operand_of(g);
        m_tag   <= g;
        m_rr    <= (g + 1) % N;
        m_phase <= 1;
      end
    end else if (m_phase < 6) begin
      m_phase <= m_phase + 1;
    end else if (dout_ready) begin
      m_phase <= 0;
    end
  end

  always @(negedge clk) begin
    int g;
    logic [N-1:0] er;
    g  = first_valid(req_valid, m_rr);
    er = '0;
    if (!rst && m_phase == 0 && g >= 0) er[g] = 1'b1;
    check("req_ready", int'(req_ready), int'(er));
    check("busy", int'(busy), int'(m_phase != 0));
    check("dout_valid", int'(dout_valid), int'(m_phase == 6));
    if (m_phase == 6) begin
      check("dout_r", int'(dout_r), m_a % 211);
      check("dout_tag", int'(dout_tag), m_tag);
    end
  end

  task automatic offer(input int idx, input int a);
    req_data[15*idx +: 15] = 15'(a);
    req_valid[idx] = 1'b1;
  endtask

  task automatic wait_grant(input int idx, input bit drop);
    int t = 0;
    @(negedge clk);
    while (!req_ready[idx] && t < 60) begin
      t++;
      @(negedge clk);
    end
    check($sformatf("grant%0d", idx), int'(req_ready[idx]), 1);
    @(posedge clk);
    #2;
    if (drop) req_valid[idx] = 1'b0;
  endtask

  task automatic wait_done(output int r, output int tag);
    int t = 0;
    @(negedge clk);
    while (!dout_valid && t < 60) begin
      t++;
      @(negedge clk);
    end
    check("result_arrives", int'(dout_valid), 1);
    r   = int'(dout_r);
    tag = int'(dout_tag);
    @(posedge clk);
    #2;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int r, tag, t;
    int sweep[$];
    int lit_a[4];
    int lit_r[4];
    lit_a = '{1000, 2000, 3000, 4000};
    lit_r = '{156, 101, 46, 202};

    // Reset values, with a requester already valid: no grant during reset.
    offer(0, 32767);
    repeat (2) @(posedge clk);
    #2;
    check("rst_valid", int'(dout_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_ready", int'(req_ready), 0);
    check("rst_r", int'(dout_r), 0);
    check("rst_tag", int'(dout_tag), 0);
    rst = 1'b0;
    #1;
    check("t1_ready", int'(req_ready), 1);
    @(posedge clk);          // accept edge
    #2 req_valid[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("t1_not_yet", int'(dout_valid), 0);
    @(posedge clk);          // 6th edge counting the accept edge
    #1;
    check("t1_valid", int'(dout_valid), 1);
    check("t1_r", int'(dout_r), 62);
    check("t1_tag", int'(dout_tag), 0);
    @(posedge clk);
    #2;

    // Residue sweep through requester 2.
    for (int a = 0; a < 3000; a++) sweep.push_back(a);
    for (int a = 32000; a < 32768; a++) sweep.push_back(a);
    for (int k = 15; k <= 155; k++) begin
      sweep.push_back(k*211 - 1);
      sweep.push_back(k*211);
      sweep.push_back(k*211 + 1);
    end
    foreach (sweep[i]) begin
      offer(2, sweep[i]);
      wait_grant(2, 1'b1);
      wait_done(r, tag);
      check("sweep_r", r, sweep[i] % 211);
      check("sweep_tag", tag, 2);
      if (sweep[i] == 0)   check("a0", r, 0);
      if (sweep[i] == 211) check("a211", r, 0);
      if (sweep[i] == 210) check("a210", r, 210);
    end

    // All four valid continuously after reset: strict round robin.
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    for (int i = 0; i < 4; i++) offer(i, lit_a[i]);
    for (int i = 0; i < 8; i++) begin
      wait_done(r, tag);
      check("rr_tag", tag, i % 4);
      check("rr_r", r, lit_r[i % 4]);
    end
    req_valid = '0;

    // Consumer stall in DONE with another requester waiting.
    dout_ready = 1'b0;
    offer(1, 5000);
    wait_grant(1, 1'b1);
    offer(3, 777);
    t = 0;
    while (!dout_valid && t < 60) begin
      t++;
      @(negedge clk);
    end
    check("stall_reach", int'(dout_valid), 1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("stall_valid", int'(dout_valid), 1);
      check("stall_r", int'(dout_r), 147);
      check("stall_tag", int'(dout_tag), 1);
      check("stall_busy", int'(busy), 1);
      check("stall_ready", int'(req_ready), 0);
    end
    @(posedge clk);
    #2 dout_ready = 1'b1;
    @(posedge clk);          // handshake edge
    #1;
    check("rel_valid", int'(dout_valid), 0);
    check("rel_busy", int'(busy), 0);
    check("rel_ready", int'(req_ready), 8);
    #1;
    wait_grant(3, 1'b1);
    wait_done(r, tag);
    check("rel_r", r, 144);
    check("rel_tag", tag, 3);

    // Reset while an operand sits in MUL_Q.
    offer(2, 1234);
    wait_grant(2, 1'b1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", int'(dout_valid), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_r", int'(dout_r), 0);
    check("mid_rst_tag", int'(dout_tag), 0);
    offer(0, 4321);
    offer(3, 999);
    check("mid_rst_ready", int'(req_ready), 0);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("post_rst_ready", int'(req_ready), 1);
    wait_grant(0, 1'b1);
    wait_done(r, tag);
    check("post_rst_r", r, 101);
    check("post_rst_tag", tag, 0);
    wait_grant(3, 1'b1);
    wait_done(r, tag);
    check("post_rst_r3", r, 155);
    check("post_rst_tag3", tag, 3);

    // Wrap search: only requester 3 valid with rr_ptr at 1.
    offer(0, 50);
    wait_grant(0, 1'b1);
    wait_done(r, tag);
    check("wrap_pre_r", r, 50);
    offer(3, 32766);
    #1;
    check("wrap_ready", int'(req_ready), 8);
    wait_grant(3, 1'b1);
    wait_done(r, tag);
    check("wrap_r", r, 61);
    check("wrap_tag", tag, 3);
    offer(1, 7);
    offer(3, 8);
    #1;
    check("wrap_rr0", int'(req_ready), 2);
    wait_grant(1, 1'b1);
    wait_done(r, tag);
    check("wrap_r1", r, 7);
    wait_grant(3, 1'b1);
    wait_done(r, tag);
    check("wrap_r3", r, 8);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
